// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit RISC multi-cycle core.
// Contents:
//   - opcode constants OP_ADD..OP_STORE (0-7); opcodes 8-15 are illegal
//   - ALU operation constants used by the controller for non-R-type work
//   - controller state encoding and the matching enum type
//   - is_illegal(): decode helper for the illegal-opcode check
package cpu_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_BEQ   = 4'd5;
    localparam logic [3:0] OP_LOAD  = 4'd6;
    localparam logic [3:0] OP_STORE = 4'd7;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_HALT   = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_FETCH  = ST_FETCH,
        S_DECODE = ST_DECODE,
        S_EXEC   = ST_EXEC,
        S_MEM    = ST_MEM,
        S_WB     = ST_WB,
        S_HALT   = ST_HALT
    } state_t;

    // Only opcodes 0-7 are defined, so the MSB alone flags an illegal one.
    function automatic logic is_illegal(input logic [3:0] op);
        return op[3];
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Memory handshake bundle between the controller and the instruction/data
// memories.
//   imem_req   : instruction fetch request (controller -> imem)
//   imem_ready : instruction data valid (imem -> controller)
//   dmem_req   : data memory request (controller -> dmem)
//   dmem_we    : data memory write, meaningful while dmem_req=1
//   dmem_ready : data access complete (dmem -> controller)
// master = controller side, slave = memory side.
interface multicycle_controller_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (
        output imem_req, dmem_req, dmem_we,
        input  imem_ready, dmem_ready
    );

    modport slave (
        input  imem_req, dmem_req, dmem_we,
        output imem_ready, dmem_ready
    );
endinterface

// File: rtl/multicycle_controller_mem_wait_timer.sv
// Wait-state counter shared by the FETCH and MEM handshakes.
//   clk, reset : system clock, synchronous active-high reset
//   clear      : clear the count (asserted on every state change)
//   inc        : one more cycle spent waiting for ready
//   limit_hit  : this is the WAIT_LIMIT-th consecutive wait cycle, so a
//                missing ready now means timeout
module mem_wait_timer #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic limit_hit
);

    localparam int W = $clog2(WAIT_LIMIT + 1);

    logic [W-1:0] count;

    // count holds the number of wait cycles already spent in the current
    // state, so it reads WAIT_LIMIT-1 during the WAIT_LIMIT-th cycle.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && !limit_hit) begin
            count <= count + W'(1);
        end
    end

    assign limit_hit = (count == W'(WAIT_LIMIT - 1));

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the 16-bit RISC core.
//   clk, reset   : system clock, synchronous active-high reset
//   run          : level enable; FSM leaves IDLE only while run=1
//   opcode       : decoded opcode (0-4 R-type, 5 BEQ, 6 LOAD, 7 STORE)
//   alu_zero     : ALU zero flag, used by BEQ in EXEC
//   mem          : imem/dmem req/ready handshakes (master side)
//   ir_write     : load instruction register
//   alu_op       : ALU operation select
//   alu_src_imm  : ALU B operand is the immediate
//   reg_write    : register file write enable
//   wb_sel_mem   : writeback data from memory
//   pc_write     : PC update strobe; pc_src selects PC+1 (0) or PC+1+imm (1)
//   fault        : sticky illegal-opcode / memory-timeout flag
//   busy         : high outside IDLE and HALT
//   instr_count  : retired instructions, wraps modulo 2^CNT_W
module multicycle_controller
    import cpu_pkg::*;
#(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic [3:0]             opcode,
    input  logic                   alu_zero,
    multicycle_controller_if.master mem,
    output logic                   ir_write,
    output logic [3:0]             alu_op,
    output logic                   alu_src_imm,
    output logic                   reg_write,
    output logic                   wb_sel_mem,
    output logic                   pc_write,
    output logic                   pc_src,
    output logic                   fault,
    output logic                   busy,
    output logic [CNT_W-1:0]       instr_count
);

    state_t state_q, state_d;
    logic   retire;
    logic   fault_set;
    logic   wait_inc;
    logic   limit_hit;

    // The timer restarts whenever the FSM changes state, so FETCH and MEM
    // each get a fresh WAIT_LIMIT budget.
    mem_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (state_d != state_q),
        .inc       (wait_inc),
        .limit_hit (limit_hit)
    );

    // State, sticky fault and the retirement counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            fault       <= 1'b0;
            instr_count <= '0;
        end else begin
            state_q <= state_d;
            if (fault_set) begin
                fault <= 1'b1;
            end
            if (retire) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    // Next-state and datapath enables. Retiring instructions return to
    // FETCH, or park in IDLE when run has been dropped meanwhile.
    always_comb begin
        state_d      = state_q;
        ir_write     = 1'b0;
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        mem.dmem_we  = 1'b0;
        alu_op       = ALU_ADD;
        alu_src_imm  = 1'b0;
        reg_write    = 1'b0;
        wb_sel_mem   = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        retire       = 1'b0;
        fault_set    = 1'b0;
        wait_inc     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                mem.imem_req = 1'b1;
                if (mem.imem_ready) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end else begin
                    wait_inc = 1'b1;
                    if (limit_hit) begin
                        fault_set = 1'b1;
                        state_d   = S_HALT;
                    end
                end
            end
            S_DECODE: begin
                if (is_illegal(opcode)) begin
                    fault_set = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (opcode)
                    OP_BEQ: begin
                        alu_op   = ALU_SUB;
                        pc_write = 1'b1;
                        pc_src   = alu_zero;
                        retire   = 1'b1;
                        state_d  = run ? S_FETCH : S_IDLE;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_op      = ALU_ADD;
                        alu_src_imm = 1'b1;
                        state_d     = S_MEM;
                    end
                    default: begin
                        alu_op  = opcode;
                        state_d = S_WB;
                    end
                endcase
            end
            S_MEM: begin
                mem.dmem_req = 1'b1;
                mem.dmem_we  = (opcode == OP_STORE);
                if (mem.dmem_ready) begin
                    if (opcode == OP_STORE) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_d  = run ? S_FETCH : S_IDLE;
                    end else begin
                        state_d = S_WB;
                    end
                end else begin
                    wait_inc = 1'b1;
                    if (limit_hit) begin
                        fault_set = 1'b1;
                        state_d   = S_HALT;
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                wb_sel_mem = (opcode == OP_LOAD);
                pc_write   = 1'b1;
                retire     = 1'b1;
                state_d    = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q != S_IDLE) && (state_q != S_HALT);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed testbench for multicycle_controller. Inputs change 1 ns after
// the rising edge and outputs are compared before the next edge. The
// counter is built 4 bits wide so that wrap-around is reachable quickly.
module tb_multicycle_controller;
    import cpu_pkg::*;

    localparam int TB_CNT_W = 4;

    logic                clk;
    logic                reset;
    logic                run;
    logic [3:0]          opcode;
    logic                alu_zero;
    logic                ir_write;
    logic [3:0]          alu_op;
    logic                alu_src_imm;
    logic                reg_write;
    logic                wb_sel_mem;
    logic                pc_write;
    logic                pc_src;
    logic                fault;
    logic                busy;
    logic [TB_CNT_W-1:0] instr_count;

    int n_cmp = 0;
    int n_bad = 0;

    multicycle_controller_if mem_bus ();

    multicycle_controller #(.WAIT_LIMIT(15), .CNT_W(TB_CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .opcode      (opcode),
        .alu_zero    (alu_zero),
        .mem         (mem_bus.master),
        .ir_write    (ir_write),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .reg_write   (reg_write),
        .wb_sel_mem  (wb_sel_mem),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .fault       (fault),
        .busy        (busy),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and land just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single comparison point: counts and reports mismatches.
    task automatic check_output(input string tag, input logic [31:0] got,
                                input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        run = 1'b0;
        opcode = OP_ADD;
        alu_zero = 1'b0;
        mem_bus.imem_ready = 1'b0;
        mem_bus.dmem_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_output("rst_busy", 32'(busy), 0);
        check_output("rst_imem_req", 32'(mem_bus.imem_req), 0);
        check_output("rst_fault", 32'(fault), 0);
        check_output("rst_count", 32'(instr_count), 0);
        check_output("rst_pc_write", 32'(pc_write), 0);

        // R-type with immediate ready: FETCH, DECODE, EXEC, WB
        run = 1'b1;
        mem_bus.imem_ready = 1'b1;
        opcode = OP_ADD;
        tick();
        check_output("r_fetch_req", 32'(mem_bus.imem_req), 1);
        check_output("r_fetch_irw", 32'(ir_write), 1);
        check_output("r_fetch_busy", 32'(busy), 1);
        tick();
        check_output("r_dec_req", 32'(mem_bus.imem_req), 0);
        check_output("r_dec_rw", 32'(reg_write), 0);
        tick();
        check_output("r_exec_aluop", 32'(alu_op), 0);
        check_output("r_exec_imm", 32'(alu_src_imm), 0);
        check_output("r_exec_pcw", 32'(pc_write), 0);
        tick();
        check_output("r_wb_rw", 32'(reg_write), 1);
        check_output("r_wb_sel", 32'(wb_sel_mem), 0);
        check_output("r_wb_pcw", 32'(pc_write), 1);
        check_output("r_wb_pcsrc", 32'(pc_src), 0);
        tick();
        check_output("r_count", 32'(instr_count), 1);
        check_output("r_next_fetch", 32'(mem_bus.imem_req), 1);

        // BEQ taken
        opcode = OP_BEQ;
        alu_zero = 1'b1;
        tick();
        tick();
        check_output("beq1_aluop", 32'(alu_op), 1);
        check_output("beq1_pcw", 32'(pc_write), 1);
        check_output("beq1_pcsrc", 32'(pc_src), 1);
        check_output("beq1_rw", 32'(reg_write), 0);
        tick();
        check_output("beq1_count", 32'(instr_count), 2);
        check_output("beq1_fetch", 32'(mem_bus.imem_req), 1);

        // BEQ not taken
        alu_zero = 1'b0;
        tick();
        tick();
        check_output("beq0_pcw", 32'(pc_write), 1);
        check_output("beq0_pcsrc", 32'(pc_src), 0);
        tick();
        check_output("beq0_count", 32'(instr_count), 3);

        // LOAD with dmem_ready arriving on the fourth MEM cycle
        opcode = OP_LOAD;
        mem_bus.dmem_ready = 1'b0;
        tick();
        tick();
        check_output("ld_exec_aluop", 32'(alu_op), 0);
        check_output("ld_exec_imm", 32'(alu_src_imm), 1);
        tick();
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) begin
                mem_bus.dmem_ready = 1'b1;
                #1;
            end
            check_output($sformatf("ld_mem%0d_req", i), 32'(mem_bus.dmem_req), 1);
            check_output($sformatf("ld_mem%0d_we", i), 32'(mem_bus.dmem_we), 0);
            check_output($sformatf("ld_mem%0d_pcw", i), 32'(pc_write), 0);
            if (i < 4) tick();
        end
        tick();
        mem_bus.dmem_ready = 1'b0;
        #1;
        check_output("ld_wb_rw", 32'(reg_write), 1);
        check_output("ld_wb_sel", 32'(wb_sel_mem), 1);
        check_output("ld_wb_pcw", 32'(pc_write), 1);
        check_output("ld_wb_dreq", 32'(mem_bus.dmem_req), 0);
        tick();
        check_output("ld_count", 32'(instr_count), 4);

        // STORE with immediate ready; ready also held outside MEM
        opcode = OP_STORE;
        mem_bus.dmem_ready = 1'b1;
        tick();
        tick();
        check_output("st_exec_imm", 32'(alu_src_imm), 1);
        tick();
        check_output("st_mem_req", 32'(mem_bus.dmem_req), 1);
        check_output("st_mem_we", 32'(mem_bus.dmem_we), 1);
        check_output("st_mem_pcw", 32'(pc_write), 1);
        check_output("st_mem_pcsrc", 32'(pc_src), 0);
        check_output("st_mem_rw", 32'(reg_write), 0);
        tick();
        check_output("st_count", 32'(instr_count), 5);
        check_output("st_fetch_dreq", 32'(mem_bus.dmem_req), 0);

        // run dropped during EXEC of an R-type
        opcode = OP_OR;
        mem_bus.dmem_ready = 1'b0;
        tick();
        tick();
        run = 1'b0;
        #1;
        check_output("rd_exec_aluop", 32'(alu_op), 3);
        tick();
        check_output("rd_wb_rw", 32'(reg_write), 1);
        tick();
        check_output("rd_idle_busy", 32'(busy), 0);
        check_output("rd_idle_req", 32'(mem_bus.imem_req), 0);
        check_output("rd_count", 32'(instr_count), 6);
        tick();
        check_output("rd_stay_idle", 32'(busy), 0);

        // Illegal opcode
        opcode = 4'd9;
        run = 1'b1;
        tick();
        tick();
        check_output("ill_dec_pcw", 32'(pc_write), 0);
        check_output("ill_dec_rw", 32'(reg_write), 0);
        check_output("ill_dec_fault", 32'(fault), 0);
        tick();
        check_output("ill_halt_fault", 32'(fault), 1);
        check_output("ill_halt_busy", 32'(busy), 0);
        check_output("ill_halt_req", 32'(mem_bus.imem_req), 0);
        check_output("ill_halt_rw", 32'(reg_write), 0);
        tick();
        tick();
        check_output("ill_stuck_fault", 32'(fault), 1);
        check_output("ill_stuck_busy", 32'(busy), 0);
        check_output("ill_count", 32'(instr_count), 6);

        // Reset exits HALT
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check_output("rst2_fault", 32'(fault), 0);
        check_output("rst2_count", 32'(instr_count), 0);

        // Fetch timeout: imem_ready held low
        mem_bus.imem_ready = 1'b0;
        opcode = OP_ADD;
        tick();
        for (int i = 1; i <= 15; i++) begin
            check_output($sformatf("to_wait%0d_req", i), 32'(mem_bus.imem_req), 1);
            check_output($sformatf("to_wait%0d_fault", i), 32'(fault), 0);
            if (i < 15) tick();
        end
        tick();
        check_output("to_halt_fault", 32'(fault), 1);
        check_output("to_halt_busy", 32'(busy), 0);
        check_output("to_halt_req", 32'(mem_bus.imem_req), 0);
        mem_bus.imem_ready = 1'b1;
        tick();
        check_output("to_late_fault", 32'(fault), 1);
        check_output("to_late_busy", 32'(busy), 0);
        check_output("to_late_irw", 32'(ir_write), 0);

        // Ready on the 15th wait cycle still completes
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mem_bus.imem_ready = 1'b0;
        tick();
        repeat (14) tick();
        mem_bus.imem_ready = 1'b1;
        #1;
        check_output("edge_irw", 32'(ir_write), 1);
        tick();
        check_output("edge_dec_busy", 32'(busy), 1);
        check_output("edge_dec_fault", 32'(fault), 0);
        check_output("edge_dec_req", 32'(mem_bus.imem_req), 0);

        // STORE retires once, then reset lands during a second STORE's MEM
        opcode = OP_STORE;
        mem_bus.dmem_ready = 1'b0;
        tick();
        tick();
        mem_bus.dmem_ready = 1'b1;
        #1;
        check_output("rm_st1_pcw", 32'(pc_write), 1);
        tick();
        check_output("rm_st1_count", 32'(instr_count), 1);
        mem_bus.dmem_ready = 1'b0;
        tick();
        tick();
        tick();
        check_output("rm_mem_req", 32'(mem_bus.dmem_req), 1);
        reset = 1'b1;
        tick();
        check_output("rm_dreq", 32'(mem_bus.dmem_req), 0);
        check_output("rm_busy", 32'(busy), 0);
        check_output("rm_count", 32'(instr_count), 0);
        reset = 1'b0;

        // Counter wrap: 17 BEQs on a 4-bit counter
        mem_bus.imem_ready = 1'b1;
        opcode = OP_BEQ;
        run = 1'b1;
        tick();
        repeat (17) begin
            tick();
            tick();
            tick();
        end
        check_output("wrap_count", 32'(instr_count), 1);
        check_output("wrap_busy", 32'(busy), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle control FSM for the 16-bit RISC core.
- Sequences each instruction through fetch, decode, execute, memory and writeback, and drives the datapath enables.
- Takes the 4-bit opcode from the instruction decoder and alu_zero from the ALU.
- Owns the instruction- and data-memory req/ready handshakes, including a wait-state timeout, and keeps a retired-instruction counter.

Parameters:
- WAIT_LIMIT, 15, maximum consecutive wait cycles on either memory handshake before a fault is raised.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- run  in  1  level; the FSM leaves IDLE only while run=1.
- opcode  in  4  decoded opcode: 0-4 ALU R-type, 5 BEQ, 6 LOAD, 7 STORE, 8-15 illegal.
- alu_zero  in  1  ALU zero flag, valid during EXEC.
- imem_ready  in  1  instruction memory data valid.
- dmem_ready  in  1  data memory access complete.
- imem_req  out  1  instruction fetch request.
- ir_write  out  1  load the instruction register.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write (STORE) when dmem_req=1.
- alu_op  out  4  ALU operation: opcode for R-type, 4'b0001 (SUB) for BEQ, 4'b0000 (ADD) for LOAD/STORE address.
- alu_src_imm  out  1  ALU B operand = zero-extended immediate.
- reg_write  out  1  register file write enable.
- wb_sel_mem  out  1  writeback data from memory (LOAD) rather than ALU.
- pc_write  out  1  PC update strobe.
- pc_src  out  1  0: PC+1, 1: PC+1+imm.
- fault  out  1  sticky: illegal opcode or memory timeout.
- busy  out  1  high in every state except IDLE and HALT.
- instr_count  out  CNT_W  instructions retired.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. Encoding is a localparam set.
- Reset: state=IDLE, wait counter=0, instr_count=0, fault=0. All other outputs are combinational from state and are 0 in IDLE.
- IDLE: go to FETCH when run=1.
- FETCH:
  - imem_req=1 until imem_ready=1; ir_write=1 in the cycle imem_ready=1, then go to DECODE.
  - Each cycle with imem_ready=0 increments the wait counter. Reaching WAIT_LIMIT sets fault=1 and goes to HALT.
- DECODE (1 cycle): register reads settle. If opcode>=8, set fault=1 and go to HALT; otherwise go to EXEC.
- EXEC (1 cycle):
  - alu_op as in Ports; alu_src_imm=1 for opcodes 6 and 7.
  - R-type goes to WB.
  - BEQ: pc_write=1, pc_src=alu_zero, instr_count increments, go to FETCH (or IDLE if run=0).
  - LOAD and STORE go to MEM.
- MEM:
  - dmem_req=1 (dmem_we=1 for STORE) held until dmem_ready=1; same WAIT_LIMIT timeout rule as FETCH.
  - On dmem_ready: LOAD goes to WB. STORE retires (pc_write=1, pc_src=0, count++) and goes to FETCH/IDLE.
- WB (1 cycle):
  - reg_write=1; wb_sel_mem=1 for LOAD.
  - pc_write=1, pc_src=0, count++, then go to FETCH, or IDLE if run=0.
- Wait counter clears on every state entry. A ready that arrives on the WAIT_LIMIT-th cycle completes normally; the timeout wins only if ready is still 0 after that cycle.
- Latency with zero wait states: R-type 4 cycles, BEQ 3, LOAD 5, STORE 4.
- run=0 mid-instruction: the current instruction completes; the FSM goes to IDLE at retirement.
- HALT: all enables 0, busy=0, fault=1. Only reset exits HALT.
- Reset mid-MEM: req drops on the next edge. No partial retirement; instr_count=0.
- instr_count wraps modulo 2^CNT_W.
- Ready asserted without a req: ignored.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants OP_ADD..OP_STORE (0-7).
  - state encoding.
  - ALU_ADD / ALU_SUB constants.
- Sub-module mem_wait_timer (counter plus limit compare), instantiated once and shared by FETCH and MEM, since it clears on state entry.

Test Plan:
- Reset, run=1, immediate readies, opcode=0 (R-type) → FETCH, DECODE, EXEC, WB; reg_write=1 in cycle 4; pc_write=1, pc_src=0; instr_count=1.
- BEQ (opcode=5) with alu_zero=1 in EXEC → pc_write=1, pc_src=1, alu_op=0001, no reg_write; 3 cycles. Repeat with alu_zero=0 → pc_src=0.
- LOAD with dmem_ready delayed 3 cycles → dmem_req high 4 cycles, dmem_we=0, then WB with wb_sel_mem=1, reg_write=1; 8 cycles total. STORE with immediate ready → dmem_we=1, no reg_write; 4 cycles.
- imem_ready held 0 → fault=1 after 15 wait cycles, state HALT, busy=0. A 16th-cycle ready is ignored; only reset clears.
- opcode=9 in DECODE → fault=1, HALT; no reg_write or pc_write ever asserted.
- Reset asserted during MEM of STORE → next cycle IDLE, dmem_req=0, instr_count=0. Also check run dropped during EXEC of R-type → WB completes, then IDLE.
